// File: rtl/mem_port_arbiter_if.sv
// Native valid/ready memory port shared by the masters and the slave side.
// master drives the request; slave returns ready/rdata.
interface mem_port_arbiter_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter for the single memory/MMIO slave port,
// with a bus-timeout watchdog that terminates unanswered transfers.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  m0,
  mem_port_arbiter_if.slave  m1,
  mem_port_arbiter_if.master s,
  output logic [1:0]         grant,
  output logic               timeout_err
);
  localparam int            CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state_reg, state_next;
  logic            s_valid_reg, s_valid_next;
  logic [31:0]     s_addr_reg, s_addr_next;
  logic [31:0]     s_wdata_reg, s_wdata_next;
  logic [3:0]      s_wstrb_reg, s_wstrb_next;
  logic [1:0]      grant_reg, grant_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            last_reg, last_next;
  logic [1:0]      ready_reg, ready_next;
  logic [1:0][31:0] rdata_reg, rdata_next;
  logic            err_reg, err_next;

  logic any_req;
  logic pick_m1;
  logic at_limit;

  assign any_req  = m0.valid | m1.valid;
  // last_reg=1 means m1 was served last, so m0 wins a tie.
  assign pick_m1  = m1.valid & (~m0.valid | ~last_reg);
  assign at_limit = (count_reg == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      s_valid_reg <= 1'b0;
      s_addr_reg  <= '0;
      s_wdata_reg <= '0;
      s_wstrb_reg <= '0;
      grant_reg   <= '0;
      count_reg   <= '0;
      last_reg    <= 1'b1;
      ready_reg   <= '0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      s_valid_reg <= s_valid_next;
      s_addr_reg  <= s_addr_next;
      s_wdata_reg <= s_wdata_next;
      s_wstrb_reg <= s_wstrb_next;
      grant_reg   <= grant_next;
      count_reg   <= count_next;
      last_reg    <= last_next;
      ready_reg   <= ready_next;
      rdata_reg   <= rdata_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (s.ready || at_limit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_valid_next = s_valid_reg;
    s_addr_next  = s_addr_reg;
    s_wdata_next = s_wdata_reg;
    s_wstrb_next = s_wstrb_reg;
    grant_next   = grant_reg;
    count_next   = count_reg;
    last_next    = last_reg;
    rdata_next   = rdata_reg;
    ready_next   = 2'b00;
    err_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          s_valid_next = 1'b1;
          s_addr_next  = pick_m1 ? m1.addr  : m0.addr;
          s_wdata_next = pick_m1 ? m1.wdata : m0.wdata;
          s_wstrb_next = pick_m1 ? m1.wstrb : m0.wstrb;
          grant_next   = pick_m1 ? 2'b10 : 2'b01;
          count_next   = '0;
        end
      end
      BUSY: begin
        // A slave answer in the limit cycle is a normal completion.
        if (s.ready) begin
          s_valid_next                = 1'b0;
          ready_next                  = grant_reg;
          rdata_next[grant_reg[1]]    = s.rdata;
        end else if (at_limit) begin
          s_valid_next                = 1'b0;
          ready_next                  = grant_reg;
          rdata_next[grant_reg[1]]    = ERR_DATA;
          err_next                    = 1'b1;
        end else begin
          count_next = count_reg + CW'(1);
        end
      end
      DONE: begin
        last_next  = grant_reg[1];
        grant_next = 2'b00;
      end
      default: ;
    endcase
  end

  assign s.valid     = s_valid_reg;
  assign s.addr      = s_addr_reg;
  assign s.wdata     = s_wdata_reg;
  assign s.wstrb     = s_wstrb_reg;
  assign m0.ready    = ready_reg[0];
  assign m1.ready    = ready_reg[1];
  assign m0.rdata    = rdata_reg[0];
  assign m1.rdata    = rdata_reg[1];
  assign grant       = grant_reg;
  assign timeout_err = err_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: vector table, reset-abort sequence and randomized
// transfers checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;
  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0, d0;
    logic [3:0]  b0;
    logic [31:0] a1, d1;
    logic [3:0]  b1;
    int          w;          // BUSY cycles before slave ready; >= TO means never
    logic [31:0] sdata;
    int          exp_win;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;    // cycles from request to master ready
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] grant;
  logic timeout_err;

  mem_port_arbiter_if m0_bus ();
  mem_port_arbiter_if m1_bus ();
  mem_port_arbiter_if s_bus ();

  mem_port_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk         (clk),
    .reset       (reset),
    .m0          (m0_bus),
    .m1          (m1_bus),
    .s           (s_bus),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          model_last;
  logic [31:0] rdata_hold [2];
  vec_t        vecs [10];

  task automatic chk(input string nm, input string field, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", nm, field, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    logic [1:0]  wg;
    logic [31:0] exp_addr, exp_wd;
    logic [3:0]  exp_wb;
    int          busy, sv_cnt, lat, got_win;
    logic        done, bus_bad, excl_bad;
    logic [31:0] got_rd, lose_rd;
    logic        got_err;
    logic [1:0]  got_grant;

    wg       = (v.exp_win == 0) ? 2'b01 : 2'b10;
    exp_addr = (v.exp_win == 0) ? v.a0 : v.a1;
    exp_wd   = (v.exp_win == 0) ? v.d0 : v.d1;
    exp_wb   = (v.exp_win == 0) ? v.b0 : v.b1;

    m0_bus.valid = v.req[0]; m0_bus.addr = v.a0; m0_bus.wdata = v.d0; m0_bus.wstrb = v.b0;
    m1_bus.valid = v.req[1]; m1_bus.addr = v.a1; m1_bus.wdata = v.d1; m1_bus.wstrb = v.b1;
    s_bus.ready  = 1'b0;
    s_bus.rdata  = v.sdata;
    busy = 0; sv_cnt = 0; lat = 0; got_win = -1;
    done = 1'b0; bus_bad = 1'b0; excl_bad = 1'b0;
    got_rd = '0; lose_rd = '0; got_err = 1'b0; got_grant = '0;

    for (int t = 1; t <= 40 && !done; t++) begin
      @(negedge clk);
      s_bus.ready = 1'b0;
      if (s_bus.valid) begin
        sv_cnt++;
        if (s_bus.addr !== exp_addr || s_bus.wdata !== exp_wd ||
            s_bus.wstrb !== exp_wb || grant !== wg)
          bus_bad = 1'b1;
        if (busy == v.w) s_bus.ready = 1'b1;
        busy++;
      end
      if (m0_bus.ready && m1_bus.ready) excl_bad = 1'b1;
      if (timeout_err && !(m0_bus.ready || m1_bus.ready)) excl_bad = 1'b1;
      if (m0_bus.ready || m1_bus.ready) begin
        done      = 1'b1;
        lat       = t;
        got_win   = m1_bus.ready ? 1 : 0;
        got_rd    = m1_bus.ready ? m1_bus.rdata : m0_bus.rdata;
        lose_rd   = (v.exp_win == 0) ? m1_bus.rdata : m0_bus.rdata;
        got_err   = timeout_err;
        got_grant = grant;
        m0_bus.valid = 1'b0;
        m1_bus.valid = 1'b0;
      end
    end

    chk(name, "completed", 32'(done), 32'd1);
    if (done) begin
      chk(name, "winner", 32'(got_win), 32'(v.exp_win));
      chk(name, "latency", 32'(lat), 32'(v.exp_lat));
      chk(name, "rdata", got_rd, v.exp_rdata);
      chk(name, "loser_rdata", lose_rd, rdata_hold[1 - v.exp_win]);
      chk(name, "timeout_err", 32'(got_err), 32'(v.exp_err));
      chk(name, "grant_done", 32'(got_grant), 32'(wg));
      chk(name, "s_valid_cycles", 32'(sv_cnt), 32'(v.exp_lat - 1));
      chk(name, "bus_stable", 32'(bus_bad), 32'd0);
      chk(name, "exclusive", 32'(excl_bad), 32'd0);
      rdata_hold[v.exp_win] = v.exp_rdata;
      model_last = v.exp_win;
    end
    m0_bus.valid = 1'b0;
    m1_bus.valid = 1'b0;
    s_bus.ready  = 1'b0;
    @(negedge clk);
    chk(name, "idle_grant", 32'(grant), 32'd0);
    chk(name, "idle_ready", 32'({m1_bus.ready, m0_bus.ready, timeout_err}), 32'd0);
    @(negedge clk);
    chk(name, "no_regrant", 32'(s_bus.valid), 32'd0);
    $display("txn %s req=%b win=%0d lat=%0d rdata=%h err=%0b", name, v.req, got_win, lat, got_rd, got_err);
  endtask

  initial begin
    vec_t r;
    int   win;

    vecs[0] = '{2'b01, 32'h0000_0010, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 1, 32'h1234_5678, 0, 32'h1234_5678, 1'b0, 3};
    vecs[1] = '{2'b11, 32'h0000_0020, 32'h0, 4'h0, 32'h0000_0024, 32'h0, 4'h0, 0, 32'h1111_1111, 1, 32'h1111_1111, 1'b0, 2};
    vecs[2] = '{2'b11, 32'h0000_0028, 32'hA0A0_A0A0, 4'hF, 32'h0000_002C, 32'h0, 4'h0, 0, 32'h2222_2222, 0, 32'h2222_2222, 1'b0, 2};
    vecs[3] = '{2'b11, 32'h0000_0030, 32'h0, 4'h0, 32'h0000_0034, 32'h5, 4'h1, 2, 32'h3333_3333, 1, 32'h3333_3333, 1'b0, 4};
    vecs[4] = '{2'b11, 32'h0000_0038, 32'h0, 4'h0, 32'h0000_003C, 32'h0, 4'h0, 0, 32'h4444_4444, 0, 32'h4444_4444, 1'b0, 2};
    vecs[5] = '{2'b10, 32'h0, 32'h0, 4'h0, 32'h1000_0000, 32'hAABB_CCDD, 4'b0011, 1, 32'h5555_5555, 1, 32'h5555_5555, 1'b0, 3};
    vecs[6] = '{2'b01, 32'h0000_0040, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 9, 32'h9999_9999, 0, 32'hDEAD_BEEF, 1'b1, 5};
    vecs[7] = '{2'b10, 32'h0, 32'h0, 4'h0, 32'h0000_0044, 32'h0, 4'h0, 3, 32'h6666_6666, 1, 32'h6666_6666, 1'b0, 5};
    vecs[8] = '{2'b10, 32'h0, 32'h0, 4'h0, 32'h0000_0048, 32'h0, 4'h0, 9, 32'h7777_7777, 1, 32'hDEAD_BEEF, 1'b1, 5};
    vecs[9] = '{2'b11, 32'h0000_004C, 32'h0, 4'h0, 32'h0000_0050, 32'h0, 4'h0, 0, 32'h8888_8888, 0, 32'h8888_8888, 1'b0, 2};

    reset = 1'b1;
    m0_bus.valid = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
    m1_bus.valid = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
    s_bus.ready = 1'b0; s_bus.rdata = '0;
    rdata_hold[0] = '0; rdata_hold[1] = '0;
    model_last = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", "s_valid", 32'(s_bus.valid), 32'd0);
    chk("reset", "grant", 32'(grant), 32'd0);
    chk("reset", "ready", 32'({m1_bus.ready, m0_bus.ready, timeout_err}), 32'd0);
    chk("reset", "s_addr", s_bus.addr, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while m1 owns the bus: abort with no ready pulse.
    m1_bus.valid = 1'b1; m1_bus.addr = 32'h0000_0200; m1_bus.wstrb = 4'h0;
    s_bus.ready = 1'b0;
    @(negedge clk);
    chk("rst_busy", "grant_pre", 32'(grant), 32'd2);
    chk("rst_busy", "s_valid_pre", 32'(s_bus.valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    m1_bus.valid = 1'b0;
    @(negedge clk);
    chk("rst_busy", "s_valid", 32'(s_bus.valid), 32'd0);
    chk("rst_busy", "grant", 32'(grant), 32'd0);
    chk("rst_busy", "m1_ready", 32'(m1_bus.ready), 32'd0);
    chk("rst_busy", "m1_rdata", m1_bus.rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", "no_late_ready", 32'({m1_bus.ready, m0_bus.ready, timeout_err}), 32'd0);
    rdata_hold[0] = '0; rdata_hold[1] = '0;
    model_last = 1;
    r = '{2'b11, 32'h0000_0060, 32'h0, 4'h0, 32'h0000_0064, 32'h0, 4'h0, 1, 32'hCAFE_0001, 0, 32'hCAFE_0001, 1'b0, 3};
    run_vec(r, "post_rst_tie");

    // Randomized transfers against a transaction-level model.
    for (int i = 0; i < 30; i++) begin
      r.req   = 2'($urandom_range(1, 3));
      r.a0    = $urandom; r.d0 = $urandom; r.b0 = 4'($urandom);
      r.a1    = $urandom; r.d1 = $urandom; r.b1 = 4'($urandom);
      r.w     = $urandom_range(0, 6);
      r.sdata = $urandom;
      if (r.req == 2'b01)      win = 0;
      else if (r.req == 2'b10) win = 1;
      else                     win = (model_last == 1) ? 0 : 1;
      r.exp_win   = win;
      r.exp_err   = (r.w >= TO);
      r.exp_rdata = (r.w >= TO) ? ERR : r.sdata;
      r.exp_lat   = (r.w >= TO) ? TO + 1 : r.w + 2;
      run_vec(r, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
